rastreador_extremos: RTL and testbench

Downstream consumer of the 4-bit combinational magnitude comparator. Accepts a stream of N unsigned samples over a valid/ready handshake and tracks the running maximum, the running minimum, and how many samples equal the maximum. Makes two comparisons per sample (sample vs max, sample vs min) through a single external comparator instance. It drives the comparator's A/B inputs and consumes its igual/maior/menor outputs.

---
 rtl/rastreador_extremos.sv | 150 +++++++++++++++
 tb/tb_rastreador_extremos.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rastreador_extremos.sv
// Tracks running max, min and max-repeat count over a run of N_AMOSTRAS samples,
// using one external magnitude comparator shared between the max and min checks.
module rastreador_extremos #(
  parameter int LARGURA    = 4,
  parameter int N_AMOSTRAS = 8,
  localparam int LARG_CONT = $clog2(N_AMOSTRAS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iniciar,
  input  logic [LARGURA-1:0]   dado,
  input  logic                 dado_valido,
  output logic                 dado_pronto,
  output logic [LARGURA-1:0]   comp_A,
  output logic [LARGURA-1:0]   comp_B,
  input  logic                 comp_igual,
  input  logic                 comp_maior,
  input  logic                 comp_menor,
  output logic [LARGURA-1:0]   valor_maior,
  output logic [LARGURA-1:0]   valor_menor,
  output logic [LARG_CONT-1:0] repeticoes_maior,
  output logic [LARG_CONT-1:0] contagem,
  output logic                 concluido,
  output logic                 erro_comparador
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESPERA  = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [LARG_CONT-1:0] N_CONT = LARG_CONT'(N_AMOSTRAS);

  estado_t              estado;
  logic [LARGURA-1:0]   amostra;
  logic                 flags_ok;

  function automatic logic um_quente(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

  function automatic logic [LARG_CONT-1:0] inc_sat(input logic [LARG_CONT-1:0] v);
    return (v == N_CONT) ? v : v + LARG_CONT'(1);
  endfunction

  assign flags_ok = um_quente({comp_igual, comp_maior, comp_menor});

  // Handshake ready and comparator operands are decoded from the state register
  always_comb begin
    dado_pronto = (estado == ESPERA);
    comp_A      = '0;
    comp_B      = '0;
    case (estado)
      CMP_MAX: begin
        comp_A = amostra;
        comp_B = valor_maior;
      end
      CMP_MIN: begin
        comp_A = amostra;
        comp_B = valor_menor;
      end
      default: begin
        comp_A = '0;
        comp_B = '0;
      end
    endcase
  end

  // Control FSM and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado           <= OCIOSO;
      amostra          <= '0;
      valor_maior      <= '0;
      valor_menor      <= '0;
      repeticoes_maior <= '0;
      contagem         <= '0;
      concluido        <= 1'b0;
      erro_comparador  <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (iniciar) begin
            valor_maior      <= '0;
            valor_menor      <= '0;
            repeticoes_maior <= '0;
            contagem         <= '0;
            concluido        <= 1'b0;
            erro_comparador  <= 1'b0;
            estado           <= ESPERA;
          end
        end
        ESPERA: begin
          if (dado_valido) begin
            amostra <= dado;
            // The first sample seeds both extremes without a comparison
            if (contagem == '0) begin
              valor_maior      <= dado;
              valor_menor      <= dado;
              repeticoes_maior <= LARG_CONT'(1);
              contagem         <= LARG_CONT'(1);
              if (N_AMOSTRAS == 1) begin
                concluido <= 1'b1;
                estado    <= FIM;
              end else begin
                estado    <= ESPERA;
              end
            end else begin
              estado <= CMP_MAX;
            end
          end
        end
        CMP_MAX: begin
          // A broken flag set counts as a tie so the max itself never moves on bad data
          if (!flags_ok) begin
            erro_comparador  <= 1'b1;
            repeticoes_maior <= inc_sat(repeticoes_maior);
          end else if (comp_maior) begin
            valor_maior      <= amostra;
            repeticoes_maior <= LARG_CONT'(1);
          end else if (comp_igual) begin
            repeticoes_maior <= inc_sat(repeticoes_maior);
          end
          estado <= CMP_MIN;
        end
        CMP_MIN: begin
          if (!flags_ok) begin
            erro_comparador <= 1'b1;
          end else if (comp_menor) begin
            valor_menor <= amostra;
          end
          contagem <= contagem + LARG_CONT'(1);
          if (contagem + LARG_CONT'(1) == N_CONT) begin
            concluido <= 1'b1;
            estado    <= FIM;
          end else begin
            estado    <= ESPERA;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rastreador_extremos.sv
// Directed and randomized bench for rastreador_extremos with a behavioural
// comparator (fault-injectable) and a running max/min/count reference model.
module tb_rastreador_extremos;

  localparam int LARGURA = 4;
  localparam int N = 8;
  localparam int LC = $clog2(N + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               iniciar = 1'b0;
  logic [LARGURA-1:0] dado = '0;
  logic               dado_valido = 1'b0;
  logic               dado_pronto;
  logic [LARGURA-1:0] comp_A, comp_B;
  logic               comp_igual, comp_maior, comp_menor;
  logic [LARGURA-1:0] valor_maior, valor_menor;
  logic [LC-1:0]      repeticoes_maior, contagem;
  logic               concluido, erro_comparador;
  logic               falha = 1'b0;

  int checks = 0;
  int fails = 0;

  // reference model state
  int m_max, m_min, m_reps, m_cnt;
  bit m_err;

  rastreador_extremos #(.LARGURA(LARGURA), .N_AMOSTRAS(N)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .dado(dado),
    .dado_valido(dado_valido), .dado_pronto(dado_pronto),
    .comp_A(comp_A), .comp_B(comp_B),
    .comp_igual(comp_igual), .comp_maior(comp_maior), .comp_menor(comp_menor),
    .valor_maior(valor_maior), .valor_menor(valor_menor),
    .repeticoes_maior(repeticoes_maior), .contagem(contagem),
    .concluido(concluido), .erro_comparador(erro_comparador)
  );

  // behavioural comparator; falha forces an illegal maior+menor pattern
  assign comp_igual = falha ? 1'b0 : (comp_A == comp_B);
  assign comp_maior = falha ? 1'b1 : (comp_A > comp_B);
  assign comp_menor = falha ? 1'b1 : (comp_A < comp_B);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_max = 0; m_min = 0; m_reps = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic model_add(input int v, input bit bad);
    if (m_cnt == 0) begin
      m_max = v; m_min = v; m_reps = 1;
    end else begin
      if (bad) begin
        m_err = 1'b1;
        if (m_reps < N) m_reps++;
      end else if (v > m_max) begin
        m_max = v; m_reps = 1;
      end else if (v == m_max) begin
        if (m_reps < N) m_reps++;
      end
      if (v < m_min) m_min = v;
    end
    m_cnt++;
  endtask

  task automatic start_run();
    @(negedge clk);
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    model_clear();
    chk("start_contagem", contagem, 0);
    chk("start_concluido", concluido, 0);
    chk("start_erro", erro_comparador, 0);
    chk("start_pronto", dado_pronto, 1);
  endtask

  // Offers one sample, waits for the handshake, checks compare-phase timing/operands
  task automatic send(input logic [3:0] v, input int gap, input bit bad, input bit pulse_ini);
    int cnt;
    bit first;
    int pmax, pmin;
    repeat (gap) @(negedge clk);
    dado = v;
    dado_valido = 1'b1;
    cnt = 0;
    while (dado_pronto !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("handshake_wait", (cnt < 20), 1);
    first = (m_cnt == 0);
    pmax = m_max;
    pmin = m_min;
    @(posedge clk); #1;
    dado = 4'($urandom);
    dado_valido = first ? 1'b0 : 1'($urandom_range(0, 1));
    if (!first) begin
      falha = bad;
      iniciar = pulse_ini;
      @(negedge clk);
      chk("cmpmax_pronto", dado_pronto, 0);
      chk("cmpmax_A", comp_A, v);
      chk("cmpmax_B", comp_B, pmax);
      @(posedge clk); #1;
      falha = 1'b0;
      iniciar = 1'b0;
      @(negedge clk);
      chk("cmpmin_pronto", dado_pronto, 0);
      chk("cmpmin_A", comp_A, v);
      chk("cmpmin_B", comp_B, pmin);
    end
    model_add(v, bad);
    @(negedge clk);
    dado_valido = 1'b0;
    chk("after_contagem", contagem, m_cnt);
    chk("after_pronto", dado_pronto, (m_cnt < N));
    chk("after_compA_idle", comp_A, 0);
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_concluido"}, concluido, 1);
    chk({tag, "_maior"}, valor_maior, m_max);
    chk({tag, "_menor"}, valor_menor, m_min);
    chk({tag, "_reps"}, repeticoes_maior, m_reps);
    chk({tag, "_contagem"}, contagem, m_cnt);
    chk({tag, "_erro"}, erro_comparador, m_err);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_maior"}, valor_maior, 0);
    chk({tag, "_menor"}, valor_menor, 0);
    chk({tag, "_reps"}, repeticoes_maior, 0);
    chk({tag, "_contagem"}, contagem, 0);
    chk({tag, "_concluido"}, concluido, 0);
    chk({tag, "_erro"}, erro_comparador, 0);
    chk({tag, "_pronto"}, dado_pronto, 0);
    chk({tag, "_compA"}, comp_A, 0);
    chk({tag, "_compB"}, comp_B, 0);
  endtask

  initial begin
    logic [3:0] s_basic [8];
    logic [3:0] s_rep   [8];
    logic [3:0] s_flt   [8];
    int cnt;
    s_basic = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd4, 4'd0, 4'd15, 4'd7};
    s_rep   = '{4'd6, 4'd6, 4'd2, 4'd6, 4'd6, 4'd1, 4'd6, 4'd6};
    s_flt   = '{4'd3, 4'd2, 4'd12, 4'd5, 4'd12, 4'd1, 4'd7, 4'd4};
    model_clear();

    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1 check_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    dado = 4'd5;
    dado_valido = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("idle");
    dado_valido = 1'b0;

    // 2. basic run
    start_run();
    for (int i = 0; i < N; i++) send(s_basic[i], 0, 1'b0, 1'b0);
    check_final("basic");
    chk("basic_max_lit", valor_maior, 15);
    chk("basic_min_lit", valor_menor, 0);

    // 3. repeated maximum
    start_run();
    for (int i = 0; i < N; i++) send(s_rep[i], 0, 1'b0, 1'b0);
    check_final("rep");
    chk("rep_reps_lit", repeticoes_maior, 6);

    // 4. random data, gaps, random valid during compares, ignored iniciar
    for (int r = 0; r < 4; r++) begin
      start_run();
      for (int i = 0; i < N; i++)
        send(4'($urandom), $urandom_range(0, 3), 1'b0, (i == 3));
      check_final("rand");
      repeat (2) @(negedge clk);
      chk("rand_fim_hold", contagem, N);
    end

    // 5. comparator fault on sample 2 (12 would otherwise become the max)
    start_run();
    for (int i = 0; i < N; i++) send(s_flt[i], $urandom_range(0, 1), (i == 2), 1'b0);
    check_final("fault");
    start_run();
    chk("fault_cleared", erro_comparador, 0);

    // 6. async reset in CMP_MIN of sample 5, then an all-zero run
    for (int i = 0; i < 4; i++) send(4'(i + 8), 0, 1'b0, 1'b0);
    dado = 4'd13;
    dado_valido = 1'b1;
    cnt = 0;
    while (dado_pronto !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst5_wait", (cnt < 20), 1);
    @(posedge clk); #1;
    dado_valido = 1'b0;
    @(posedge clk); #1;
    chk("rst5_in_cmpmin", comp_A, 13);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_midreset");
    start_run();
    for (int i = 0; i < N; i++) send(4'd0, 0, 1'b0, 1'b0);
    check_final("zeros");
    chk("zeros_reps_lit", repeticoes_maior, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
